// File: rtl/ssd_refresh_divider_if.sv
// Control/status bundle between a controller and the SSD refresh divider.
// Latency: n/a (signal bundle only).
// Backpressure: none; the divider consumes controls every cycle and never stalls.
// master: drives en/mode/div_load/div_value and observes the divider outputs.
// slave : the divider itself, which produces clk_div/tick/digit_sel/anode/div_active.
interface ssd_refresh_divider_if #(
  parameter int CNT_WIDTH = 16,
  parameter int DIGITS    = 4,
  parameter int DIG_WIDTH = 2
);
  logic                 en;
  logic                 mode;
  logic                 div_load;
  logic [CNT_WIDTH-1:0] div_value;
  logic                 clk_div;
  logic                 tick;
  logic [DIG_WIDTH-1:0] digit_sel;
  logic [DIGITS-1:0]    anode;
  logic [CNT_WIDTH-1:0] div_active;

  modport master (
    output en, mode, div_load, div_value,
    input  clk_div, tick, digit_sel, anode, div_active
  );

  modport slave (
    input  en, mode, div_load, div_value,
    output clk_div, tick, digit_sel, anode, div_active
  );
endinterface

// File: rtl/ssd_refresh_divider.sv
// Programmable refresh divider: divided clock, tick pulse and SSD digit scan.
// Latency: all outputs registered; a terminal count shows up one edge after it is sampled.
// Backpressure: none; en=0 freezes counting and scanning, div_load is always accepted.
// Ports: clk, rst (async, active-high) and bus (slave modport):
//   inputs  en, mode (0 square / 1 pulse), div_load strobe, div_value
//   outputs clk_div, tick, digit_sel, anode (active-low one-hot), div_active
module ssd_refresh_divider #(
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 4999,
  parameter int DIGITS      = 4,
  parameter int DIG_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ssd_refresh_divider_if.slave  bus
);

  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] div_active;
  logic [CNT_WIDTH-1:0] pend_dat;
  logic                 pend_vld;
  logic                 clk_div;
  logic                 tick;
  logic [DIG_WIDTH-1:0] digit_sel;
  logic [DIGITS-1:0]    anode;

  logic                 term;
  logic [DIG_WIDTH-1:0] digit_nxt;
  logic [DIGITS-1:0]    anode_nxt;

  // Terminal edge: enabled and the counter has reached the active divisor.
  assign term = bus.en && (count == div_active);

  // Explicit wrap keeps digit_sel below DIGITS even when DIGITS < 2**DIG_WIDTH.
  assign digit_nxt = (digit_sel == DIG_WIDTH'(DIGITS - 1)) ? '0 : digit_sel + DIG_WIDTH'(1);
  assign anode_nxt = ~(DIGITS'(1) << digit_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      div_active <= CNT_WIDTH'(DEFAULT_DIV);
      pend_dat   <= '0;
      pend_vld   <= 1'b0;
      clk_div    <= 1'b0;
      tick       <= 1'b0;
      digit_sel  <= '0;
      anode      <= ~DIGITS'(1);
    end else begin
      if (term) begin
        count     <= '0;
        tick      <= 1'b1;
        clk_div   <= bus.mode ? 1'b1 : ~clk_div;
        digit_sel <= digit_nxt;
        anode     <= anode_nxt;
        // The divisor only changes when count restarts from 0, so count can
        // never run past div_active.
        if (pend_vld) begin
          div_active <= pend_dat;
          pend_vld   <= 1'b0;
        end
      end else if (bus.en) begin
        count   <= count + CNT_WIDTH'(1);
        tick    <= 1'b0;
        clk_div <= bus.mode ? 1'b0 : clk_div;
      end else begin
        tick    <= 1'b0;
        clk_div <= bus.mode ? 1'b0 : clk_div;
      end

      // Placed after the terminal update so a load coinciding with a terminal
      // edge leaves the new value pending (later non-blocking write wins).
      if (bus.div_load) begin
        pend_dat <= bus.div_value;
        pend_vld <= 1'b1;
      end
    end
  end

  assign bus.clk_div    = clk_div;
  assign bus.tick       = tick;
  assign bus.digit_sel  = digit_sel;
  assign bus.anode      = anode;
  assign bus.div_active = div_active;

endmodule

// File: tb/tb_ssd_refresh_divider.sv
// Directed bench for ssd_refresh_divider: vector table for steady-state
// division in both modes, then hand-written sequences for reload, enable
// freeze, divide-by-one and asynchronous reset.
module tb_ssd_refresh_divider;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ssd_refresh_divider_if #(.CNT_WIDTH(16), .DIGITS(4), .DIG_WIDTH(2)) bus ();
  ssd_refresh_divider_if #(.CNT_WIDTH(16), .DIGITS(3), .DIG_WIDTH(2)) bus3 ();

  ssd_refresh_divider #(.CNT_WIDTH(16), .DEFAULT_DIV(4), .DIGITS(4), .DIG_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Three-digit instance: digit index must wrap at 2, never reach 3.
  ssd_refresh_divider #(.CNT_WIDTH(16), .DEFAULT_DIV(4), .DIGITS(3), .DIG_WIDTH(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  assign bus3.en        = bus.en;
  assign bus3.mode      = bus.mode;
  assign bus3.div_load  = bus.div_load;
  assign bus3.div_value = bus.div_value;

  typedef struct {
    logic        en;
    logic        mode;
    logic        tick;
    logic        clk_div;
    logic [1:0]  dsel;
    logic [1:0]  dsel3;
    logic [15:0] active;
  } vec_t;

  vec_t vecs[30];

  function automatic logic [3:0] anode4(input logic [1:0] d);
    case (d)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [2:0] anode3(input logic [1:0] d);
    case (d)
      2'd0:    return 3'b110;
      2'd1:    return 3'b101;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check(input string tag, input logic tk, input logic cd,
                       input logic [1:0] ds, input logic [15:0] act);
    cmp({tag, " tick"},       32'(bus.tick),       32'(tk));
    cmp({tag, " clk_div"},    32'(bus.clk_div),    32'(cd));
    cmp({tag, " digit_sel"},  32'(bus.digit_sel),  32'(ds));
    cmp({tag, " anode"},      32'(bus.anode),      32'(anode4(ds)));
    cmp({tag, " div_active"}, 32'(bus.div_active), 32'(act));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] d;

    bus.en        = 1'b0;
    bus.mode      = 1'b0;
    bus.div_load  = 1'b0;
    bus.div_value = '0;

    // Edges 1..20 square mode, 21..30 pulse mode, divisor 4 (period 5).
    for (int e = 1; e <= 30; e++) begin
      vecs[e-1].en      = 1'b1;
      vecs[e-1].mode    = (e > 20);
      vecs[e-1].tick    = (e % 5 == 0);
      vecs[e-1].clk_div = (e > 20) ? (e % 5 == 0) : 1'((e / 5) % 2);
      vecs[e-1].dsel    = 2'((e / 5) % 4);
      vecs[e-1].dsel3   = 2'((e / 5) % 3);
      vecs[e-1].active  = 16'd4;
    end

    #2 rst = 1'b1;
    step();
    step();
    check("reset", 1'b0, 1'b0, 2'd0, 16'd4);
    cmp("reset dut3 anode", 32'(bus3.anode), 32'(3'b110));

    bus.en = 1'b1;
    rst    = 1'b0;

    for (int i = 0; i < 30; i++) begin
      bus.en   = vecs[i].en;
      bus.mode = vecs[i].mode;
      step();
      check($sformatf("vec%0d", i + 1), vecs[i].tick, vecs[i].clk_div, vecs[i].dsel, vecs[i].active);
      cmp($sformatf("vec%0d dut3 digit_sel", i + 1), 32'(bus3.digit_sel), 32'(vecs[i].dsel3));
      cmp($sformatf("vec%0d dut3 anode", i + 1), 32'(bus3.anode), 32'(anode3(vecs[i].dsel3)));
    end

    // Reload to 2 while mid-period (pulse mode, clk_div mirrors tick).
    step();
    check("s3 c1", 1'b0, 1'b0, 2'd2, 16'd4);
    bus.div_load = 1'b1; bus.div_value = 16'd2;
    step();
    check("s3 load", 1'b0, 1'b0, 2'd2, 16'd4);
    bus.div_load = 1'b0;
    step(); check("s3 c3", 1'b0, 1'b0, 2'd2, 16'd4);
    step(); check("s3 c4", 1'b0, 1'b0, 2'd2, 16'd4);
    step(); check("s3 T", 1'b1, 1'b1, 2'd3, 16'd2);
    d = 2'd3;
    for (int p = 0; p < 2; p++) begin
      repeat (2) begin
        step(); check("s3 gap", 1'b0, 1'b0, d, 16'd2);
      end
      d = d + 2'd1;
      step(); check("s3 T3", 1'b1, 1'b1, d, 16'd2);
    end

    // Pending 7, then a new load lands on the terminal edge.
    bus.div_load = 1'b1; bus.div_value = 16'd7;
    step(); check("s4 load7", 1'b0, 1'b0, 2'd1, 16'd2);
    bus.div_load = 1'b0;
    step(); check("s4 c2", 1'b0, 1'b0, 2'd1, 16'd2);
    bus.div_load = 1'b1; bus.div_value = 16'd9;
    step(); check("s4 T7", 1'b1, 1'b1, 2'd2, 16'd7);
    bus.div_load = 1'b0;
    repeat (7) begin
      step(); check("s4 gap7", 1'b0, 1'b0, 2'd2, 16'd7);
    end
    step(); check("s4 T9", 1'b1, 1'b1, 2'd3, 16'd9);
    bus.div_load = 1'b1; bus.div_value = 16'd4;
    step(); check("s4 load4", 1'b0, 1'b0, 2'd3, 16'd9);
    bus.div_load = 1'b0;
    repeat (8) begin
      step(); check("s4 gap9", 1'b0, 1'b0, 2'd3, 16'd9);
    end
    step(); check("s4 T4", 1'b1, 1'b1, 2'd0, 16'd4);

    // Square mode, freeze with en low at count 3.
    bus.mode = 1'b0;
    repeat (3) begin
      step(); check("s5 run", 1'b0, 1'b1, 2'd0, 16'd4);
    end
    bus.en = 1'b0;
    repeat (6) begin
      step(); check("s5 frozen", 1'b0, 1'b1, 2'd0, 16'd4);
    end
    bus.en = 1'b1;
    step(); check("s5 c4", 1'b0, 1'b1, 2'd0, 16'd4);
    step(); check("s5 T", 1'b1, 1'b0, 2'd1, 16'd4);

    // Divisor 0: terminal every enabled edge.
    bus.div_load = 1'b1; bus.div_value = 16'd0;
    step(); check("s6 load0", 1'b0, 1'b0, 2'd1, 16'd4);
    bus.div_load = 1'b0;
    repeat (3) begin
      step(); check("s6 run", 1'b0, 1'b0, 2'd1, 16'd4);
    end
    step(); check("s6 T a", 1'b1, 1'b1, 2'd2, 16'd0);
    step(); check("s6 T b", 1'b1, 1'b0, 2'd3, 16'd0);
    step(); check("s6 T c", 1'b1, 1'b1, 2'd0, 16'd0);
    bus.div_load = 1'b1; bus.div_value = 16'd1;
    step(); check("s6 T d", 1'b1, 1'b0, 2'd1, 16'd0);
    bus.div_load = 1'b0;

    // Asynchronous reset between edges; pending value 1 must be discarded.
    #2 rst = 1'b1;
    #1 check("async rst", 1'b0, 1'b0, 2'd0, 16'd4);
    step(); check("rst hold", 1'b0, 1'b0, 2'd0, 16'd4);
    rst = 1'b0;
    repeat (4) begin
      step(); check("post rst run", 1'b0, 1'b0, 2'd0, 16'd4);
    end
    step(); check("post rst T1", 1'b1, 1'b1, 2'd1, 16'd4);
    repeat (4) begin
      step(); check("post rst run2", 1'b0, 1'b1, 2'd1, 16'd4);
    end
    step(); check("post rst T2", 1'b1, 1'b0, 2'd2, 16'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_refresh_divider.md
Name: ssd_refresh_divider

Overview:
Parametrised successor to the fixed /5000 SSD refresh divider. Generates a divided clock and a one-cycle tick from a runtime-loadable terminal count, in square-wave or pulse mode, with an enable. It also drives the multiplexed-display digit scan (digit index plus active-low one-hot anodes) directly from the tick. Sits between the board clock and the SSD digit mux / segment decoder.

Parameters:
CNT_WIDTH, 16, width of the divide counter and divisor registers.
DEFAULT_DIV, 4999, terminal count loaded at reset. 4999 at 100 MHz gives a 10 kHz Clk_Div in square mode.
DIGITS, 4, number of SSD digits scanned. Must be 2 or more.
DIG_WIDTH, 2, width of Digit_Sel. 2^DIG_WIDTH must be at least DIGITS.

Ports:
Clk  in  1  system clock; all state updates on the rising edge.
Reset  in  1  asynchronous, active-high reset.
En  in  1  count enable; when low, all counting and scanning freeze.
Mode  in  1  0 = square wave (Clk_Div toggles at terminal); 1 = pulse (Clk_Div high for one cycle at terminal).
Div_Load  in  1  one-cycle strobe that captures Div_Value as the pending terminal count.
Div_Value  in  CNT_WIDTH  new terminal count.
Clk_Div  out  1  divided output, registered.
Tick  out  1  one-cycle pulse per terminal count, registered.
Digit_Sel  out  DIG_WIDTH  index of the currently active digit.
Anode  out  DIGITS  active-low one-hot digit enable; bit Digit_Sel is low.
Div_Active  out  CNT_WIDTH  terminal count currently in use.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-period):
  - count = 0, Div_Active = DEFAULT_DIV, pending cleared.
  - Clk_Div = 0, Tick = 0, Digit_Sel = 0.
  - Anode = all ones except bit 0 = 0.
- Terminal condition T: En = 1 and count == Div_Active, sampled at the rising edge.
- At a T edge:
  - count <= 0 and Tick <= 1.
  - Clk_Div <= ~Clk_Div in mode 0; Clk_Div <= 1 in mode 1.
  - Digit_Sel <= Digit_Sel + 1, wrapping from DIGITS-1 to 0.
  - Anode <= ~(1 << next Digit_Sel), updated in the same cycle as Digit_Sel.
- At an enabled non-T edge:
  - count <= count + 1 and Tick <= 0.
  - Clk_Div holds in mode 0 and goes to 0 in mode 1.
  - Digit_Sel and Anode hold.
- En = 0:
  - count, Clk_Div (mode 0), Digit_Sel and Anode hold.
  - Tick <= 0. In mode 1, Clk_Div <= 0.
  - Div_Load is still captured into the pending register.
- Periods:
  - Tick period = Div_Active+1 enabled cycles.
  - Mode 0: Clk_Div period = 2*(Div_Active+1) cycles, 50% duty.
  - Mode 1: Clk_Div is high 1 cycle out of every Div_Active+1.
- Divisor update (glitch-free):
  - Div_Load captures Div_Value into the pending register and sets the pending flag.
  - The pending value is applied only at a T edge: Div_Active <= pending, flag cleared, count <= 0.
  - Div_Load on the same edge as T: any older pending value is applied now; the new value becomes pending, with the flag remaining set.
  - Back-to-back Div_Load without an intervening T: the last value wins.
- Div_Active = 0: T fires on every enabled edge. Tick stays high continuously. Mode 0 gives Clk/2; mode 1 holds Clk_Div high.
- count never exceeds Div_Active, because the divisor changes only when count returns to 0. No overflow path exists.
- Mode change mid-period: takes effect at the next edge and does not reset count or Digit_Sel.
- Digit_Sel never takes values of DIGITS or above, even when DIGITS < 2^DIG_WIDTH.

Test Plan:
1. DEFAULT_DIV=4, Mode=0, En=1, release Reset → Tick high 1 cycle every 5 cycles; Clk_Div toggles on those edges (period 10 cycles); Digit_Sel steps 0,1,2,3,0 and Anode steps 1110,1101,1011,0111,1110.
2. Mode=1, DEFAULT_DIV=4 → Clk_Div high exactly 1 cycle in 5, coincident with Tick.
3. Div_Load with Div_Value=2 at count=1 → current period still ends at count=4; subsequent Tick spacing is 3 cycles; Div_Active reads 2 only after that T edge.
4. Div_Load on the T edge while pending=7, then Div_Value=9 → 7 applied at that edge; 9 applied at the next T.
5. En low for 6 cycles at count=3 → count, Clk_Div and Digit_Sel frozen and Tick=0; count resumes at 4 after En returns.
6. Div_Value=0 loaded → after the next T, Tick constantly 1 and Clk_Div toggles every cycle; Reset asserted mid-run → all outputs at reset values asynchronously and Div_Active back to 4.
